// File: rtl/hex_keypad_entry.sv
// 4x4 hex keypad scanner: column scan, scan-level debounce, and a 4-digit
// shift buffer whose contents feed the 7-segment display driver directly.
module hex_keypad_entry #(
  parameter int unsigned SCAN_DIV       = 131072,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  row,
  output logic [3:0]  col,
  input  logic        clear,
  output logic [15:0] digits,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic [2:0]  digit_count
);

  localparam int unsigned DIV_W = $clog2(SCAN_DIV);
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_SCANS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESS_DB,
    S_HELD,
    S_REL_DB
  } state_t;

  logic [3:0]       r_row_meta;
  logic [3:0]       r_row_sync;
  logic [DIV_W-1:0] r_div;
  logic [1:0]       r_colidx;
  logic [15:0]      r_map;
  logic [15:0]      w_map_next;
  logic             w_sample;
  logic             w_boundary;

  logic             w_none;
  logic             w_single;
  logic [3:0]       w_idx;
  logic [3:0]       w_code;

  state_t           r_state;
  state_t           w_state_next;
  logic [3:0]       r_cand;
  logic [3:0]       w_cand_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_accept;

  logic [15:0]      r_digits;
  logic [3:0]       r_key_code;
  logic             r_key_valid;
  logic [2:0]       r_digit_count;

  // Key position (row*4 + col) to hex value.
  function automatic logic [3:0] key_lut(input logic [3:0] idx);
    logic [3:0] v;
    case (idx)
      4'd0:  v = 4'h1;
      4'd1:  v = 4'h2;
      4'd2:  v = 4'h3;
      4'd3:  v = 4'hA;
      4'd4:  v = 4'h4;
      4'd5:  v = 4'h5;
      4'd6:  v = 4'h6;
      4'd7:  v = 4'hB;
      4'd8:  v = 4'h7;
      4'd9:  v = 4'h8;
      4'd10: v = 4'h9;
      4'd11: v = 4'hC;
      4'd12: v = 4'h0;
      4'd13: v = 4'hF;
      4'd14: v = 4'hE;
      default: v = 4'hD;
    endcase
    return v;
  endfunction

  assign w_sample   = (r_div == DIV_LAST);
  assign w_boundary = w_sample && (r_colidx == 2'd3);

  // Active-low one-hot column drive from the scan index.
  always_comb begin
    col           = '1;
    col[r_colidx] = 1'b0;
  end

  // Pressed map including the sample taken this cycle, so the classifier at
  // the scan boundary already sees the col3 result.
  always_comb begin
    w_map_next = r_map;
    if (w_sample) begin
      w_map_next[{2'd0, r_colidx}] = ~r_row_sync[0];
      w_map_next[{2'd1, r_colidx}] = ~r_row_sync[1];
      w_map_next[{2'd2, r_colidx}] = ~r_row_sync[2];
      w_map_next[{2'd3, r_colidx}] = ~r_row_sync[3];
    end
  end

  // Row synchroniser, column divider and per-scan pressed map.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_row_meta <= '1;
      r_row_sync <= '1;
      r_div      <= '0;
      r_colidx   <= '0;
      r_map      <= '0;
    end else begin
      r_row_meta <= row;
      r_row_sync <= r_row_meta;
      if (w_sample) begin
        r_div    <= '0;
        r_colidx <= r_colidx + 2'd1;
        r_map    <= w_map_next;
      end else begin
        r_div    <= r_div + DIV_W'(1);
      end
    end
  end

  // Classify a full scan as none / single key / multiple keys.
  always_comb begin
    w_none   = (w_map_next == '0);
    w_single = !w_none && ((w_map_next & (w_map_next - 16'd1)) == '0);
    w_idx    = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (w_map_next[i]) w_idx = 4'(i);
    end
    w_code   = key_lut(w_idx);
  end

  // Debounce FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cand  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cand  <= w_cand_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Debounce FSM next state; only advances at scan boundaries.
  always_comb begin
    w_state_next = r_state;
    w_cand_next  = r_cand;
    w_cnt_next   = r_cnt;
    w_accept     = 1'b0;
    if (w_boundary) begin
      case (r_state)
        S_IDLE: begin
          if (w_single) begin
            w_cand_next = w_code;
            if (DEBOUNCE_SCANS == 1) begin
              w_accept     = 1'b1;
              w_state_next = S_HELD;
              w_cnt_next   = '0;
            end else begin
              w_state_next = S_PRESS_DB;
              w_cnt_next   = CNT_ONE;
            end
          end
        end
        S_PRESS_DB: begin
          if (w_single && (w_code == r_cand)) begin
            if ((r_cnt + CNT_ONE) == CNT_DONE) begin
              w_accept     = 1'b1;
              w_state_next = S_HELD;
              w_cnt_next   = '0;
            end else begin
              w_cnt_next   = r_cnt + CNT_ONE;
            end
          end else if (w_single) begin
            w_cand_next = w_code;
            w_cnt_next  = CNT_ONE;
          end else begin
            w_state_next = S_IDLE;
            w_cnt_next   = '0;
          end
        end
        S_HELD: begin
          if (w_none) begin
            if (DEBOUNCE_SCANS == 1) begin
              w_state_next = S_IDLE;
              w_cnt_next   = '0;
            end else begin
              w_state_next = S_REL_DB;
              w_cnt_next   = CNT_ONE;
            end
          end
        end
        S_REL_DB: begin
          if (w_none) begin
            if ((r_cnt + CNT_ONE) == CNT_DONE) begin
              w_state_next = S_IDLE;
              w_cnt_next   = '0;
            end else begin
              w_cnt_next   = r_cnt + CNT_ONE;
            end
          end else begin
            w_state_next = S_HELD;
            w_cnt_next   = '0;
          end
        end
        default: begin
          w_state_next = S_IDLE;
          w_cnt_next   = '0;
        end
      endcase
    end
  end

  // Accept pulse, last key code, digit buffer; clear wins over an accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_digits      <= '0;
      r_key_code    <= '0;
      r_key_valid   <= 1'b0;
      r_digit_count <= '0;
    end else begin
      r_key_valid <= w_accept;
      if (w_accept) r_key_code <= w_cand_next;
      if (clear) begin
        r_digits      <= '0;
        r_digit_count <= '0;
      end else if (w_accept) begin
        r_digits <= {r_digits[11:0], w_cand_next};
        if (r_digit_count != 3'd4) r_digit_count <= r_digit_count + 3'd1;
      end
    end
  end

  assign digits      = r_digits;
  assign key_code    = r_key_code;
  assign key_valid   = r_key_valid;
  assign digit_count = r_digit_count;

endmodule

// File: tb/tb_hex_keypad_entry.sv
// Randomised and directed bench for hex_keypad_entry with a scan-level
// reference model built from a history window of scan classifications.
module tb_hex_keypad_entry;

  localparam int unsigned SCAN_DIV = 8;
  localparam int unsigned DB       = 2;
  localparam int          SCAN_LEN = 4 * SCAN_DIV;
  localparam int          NONE_C   = -1;
  localparam int          MULTI_C  = -2;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  row;
  logic [3:0]  col;
  logic        clear;
  logic [15:0] digits;
  logic [3:0]  key_code;
  logic        key_valid;
  logic [2:0]  digit_count;

  logic [15:0] pressed;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state.
  int          keymap [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 0, 15, 14, 13};
  int          hist [$];
  bit          m_armed;
  bit          m_kv;
  logic [3:0]  m_code;
  logic [15:0] m_digits;
  int          m_count;

  hex_keypad_entry #(
    .SCAN_DIV       (SCAN_DIV),
    .DEBOUNCE_SCANS (DB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .row         (row),
    .col         (col),
    .clear       (clear),
    .digits      (digits),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .digit_count (digit_count)
  );

  always #5 clk = ~clk;

  // Keypad: a pressed key pulls its row low while its column is driven.
  always_comb begin
    row = '1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4 + c] && !col[c]) row[r] = 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    hist.delete();
    m_armed  = 1'b1;
    m_kv     = 1'b0;
    m_code   = '0;
    m_digits = '0;
    m_count  = 0;
  endtask

  function automatic bit window_all(input int v);
    if (hist.size() < DB) return 1'b0;
    for (int j = hist.size() - DB; j < hist.size(); j++)
      if (hist[j] != v) return 1'b0;
    return 1'b1;
  endfunction

  // One press yields one accept: a key is taken when the last DB scans all
  // show that same lone key while armed; re-armed after DB empty scans.
  task automatic model_scan(input logic [15:0] mask, input int clr_cyc);
    int cls;
    bit acc;
    if ($countones(mask) == 0)      cls = NONE_C;
    else if ($countones(mask) > 1)  cls = MULTI_C;
    else begin
      cls = 0;
      for (int b = 0; b < 16; b++) if (mask[b]) cls = keymap[b];
    end
    hist.push_back(cls);
    acc = 1'b0;
    if (m_armed) begin
      if (cls >= 0 && window_all(cls)) begin
        acc     = 1'b1;
        m_armed = 1'b0;
      end
    end else if (window_all(NONE_C)) begin
      m_armed = 1'b1;
    end
    if (clr_cyc >= 0 && clr_cyc < SCAN_LEN - 1) begin
      m_digits = '0;
      m_count  = 0;
    end
    m_kv = acc;
    if (acc) begin
      m_code   = 4'(cls);
      m_digits = {m_digits[11:0], 4'(cls)};
      if (m_count < 4) m_count++;
    end
    if (clr_cyc == SCAN_LEN - 1) begin
      m_digits = '0;
      m_count  = 0;
    end
  endtask

  task automatic check_outputs();
    check("key_valid",   32'(key_valid),   32'(m_kv));
    check("key_code",    32'(key_code),    32'(m_code));
    check("digits",      32'(digits),      32'(m_digits));
    check("digit_count", 32'(digit_count), 32'(m_count));
  endtask

  // Runs one full scan with a fixed key pattern; entered at cycle 0 of a scan.
  task automatic do_scan(input logic [15:0] mask, input int clr_cyc);
    logic [3:0] ec;
    pressed = mask;
    for (int i = 0; i < SCAN_LEN; i++) begin
      if (i == 0) check_outputs();
      else        check("key_valid_idle", 32'(key_valid), 32'(0));
      ec = 4'hF;
      ec[i / SCAN_DIV] = 1'b0;
      check("col", 32'(col), 32'(ec));
      clear = (i == clr_cyc);
      @(posedge clk); #1;
    end
    clear = 1'b0;
    model_scan(mask, clr_cyc);
  endtask

  task automatic press(input int idx, input int hold, input int rel);
    for (int s = 0; s < hold; s++) do_scan(16'(1) << idx, -1);
    for (int s = 0; s < rel; s++)  do_scan('0, -1);
  endtask

  initial begin
    int kind, len, idx, idx2, clr;
    rst     = 1'b1;
    clear   = 1'b0;
    pressed = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_outputs();
    check("col_reset", 32'(col), 32'(4'b1110));
    rst = 1'b0;

    // Idle scans.
    for (int s = 0; s < 5; s++) do_scan('0, -1);
    // "5" held 6 scans.
    press(5, 6, 3);
    // 1, A, 3, F, 7.
    press(0, 3, 3);
    press(3, 3, 3);
    press(2, 3, 3);
    press(13, 3, 3);
    check("digits_1A3F", 32'(digits), 32'(16'h1A3F));
    press(8, 3, 3);
    check("digits_A3F7", 32'(digits), 32'(16'hA3F7));
    // Short "9" and "2"+"3" together.
    press(10, 1, 3);
    for (int s = 0; s < 5; s++) do_scan(16'b0000_0000_0000_0110, -1);
    for (int s = 0; s < 3; s++) do_scan('0, -1);
    check("digits_noise", 32'(digits), 32'(16'hA3F7));
    // "C" with a one-scan dropout while held.
    press(11, 3, 1);
    press(11, 3, 3);

    // Reset during press debounce.
    do_scan(16'(1) << 6, -1);
    check_outputs();
    repeat (10) begin @(posedge clk); #1; end
    rst     = 1'b1;
    pressed = '0;
    @(posedge clk); #1;
    check("rst_col",         32'(col),         32'(4'b1110));
    check("rst_digits",      32'(digits),      32'(0));
    check("rst_key_code",    32'(key_code),    32'(0));
    check("rst_key_valid",   32'(key_valid),   32'(0));
    check("rst_digit_count", 32'(digit_count), 32'(0));
    rst = 1'b0;
    model_reset();

    // Load 1234, then clear on the accept cycle of "E".
    do_scan('0, 5);
    press(0, 2, 2);
    press(1, 2, 2);
    press(2, 2, 2);
    press(4, 2, 2);
    check("digits_1234", 32'(digits), 32'(16'h1234));
    do_scan(16'(1) << 14, -1);
    do_scan(16'(1) << 14, SCAN_LEN - 1);
    check("clr_key_valid",   32'(key_valid),   32'(1));
    check("clr_key_code",    32'(key_code),    32'(4'hE));
    check("clr_digits",      32'(digits),      32'(0));
    check("clr_digit_count", 32'(digit_count), 32'(0));
    do_scan('0, -1);
    do_scan('0, -1);

    // Randomised segments.
    for (int seg = 0; seg < 60; seg++) begin
      kind = $urandom_range(0, 9);
      len  = $urandom_range(1, 4);
      idx  = $urandom_range(0, 15);
      idx2 = (idx + $urandom_range(1, 15)) % 16;
      for (int s = 0; s < len; s++) begin
        clr = ($urandom_range(0, 9) == 0) ? $urandom_range(0, SCAN_LEN - 1) : -1;
        if (kind <= 5)      do_scan(16'(1) << idx, clr);
        else if (kind == 6) do_scan((16'(1) << idx) | (16'(1) << idx2), clr);
        else if (kind == 7) do_scan((s == 1) ? '0 : (16'(1) << idx), clr);
        else if (kind == 8) do_scan((s % 2 == 0) ? (16'(1) << idx) : (16'(1) << idx2), clr);
        else                do_scan('0, clr);
      end
    end
    for (int s = 0; s < 3; s++) do_scan('0, -1);
    check_outputs();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hex_keypad_entry.md
Name: hex_keypad_entry

Overview:
- Input-side counterpart of the board's 4-digit hex display path: scans a 4x4 hex keypad, debounces it, and decodes it into a 16-bit value.
- Drives keypad columns one at a time and samples the rows. Each accepted keypress is shifted into a 4-digit buffer.
- The `digits` output connects directly to the display driver's 16-bit digit input, so typed values echo on the 7-segment display.

Parameters:
- SCAN_DIV, 131072: clk cycles each column is driven; must be ≥4.
- DEBOUNCE_SCANS, 4: consecutive identical full scans required to accept a press or a release; must be ≥1.

Ports:
- clk  input  1  system clock (100 MHz on board)
- rst  input  1  synchronous, active-high reset
- row  input  4  keypad rows, active-low, externally pulled up; asynchronous to clk
- col  output  4  keypad column drive, active-low, exactly one bit low at all times
- clear  input  1  synchronous; zeroes the digit buffer
- digits  output  16  entered value; newest digit in [3:0]
- key_code  output  4  hex value of the most recently accepted key
- key_valid  output  1  one-cycle pulse when a key is accepted
- digit_count  output  3  digits entered since reset/clear, saturates at 4

Behaviour:
- Reset values (all outputs and state are reset synchronously by rst, including mid-scan and mid-debounce):
  - col=4'b1110, digits=0, key_code=0, key_valid=0, digit_count=0
  - scan column index=0, divider=0, FSM=IDLE, debounce counter=0
- Input synchronisation: row passes through a 2-flop synchroniser before any use.
- Column scan:
  - col steps 1110 → 1101 → 1011 → 0111 → 1110 (col0..col3), each held exactly SCAN_DIV cycles.
  - The synchronised row is sampled on the last cycle of each column slot, giving SCAN_DIV−3 cycles of settling.
  - One full scan lasts 4*SCAN_DIV cycles and produces a 16-bit pressed map (bit = ~row).
- Key map, (row r, col c) → code:
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: 0 F E D
- Scan classification, evaluated at the end of the col3 slot (scan boundary):
  - NONE: zero keys pressed.
  - SINGLE(k): exactly one key pressed, decoded to code k.
  - MULTI: two or more keys pressed.
- FSM (advances only at scan boundaries; cnt = debounce counter):
  - IDLE:
    - SINGLE(k) → PRESS_DB, cand=k, cnt=1. If DEBOUNCE_SCANS=1, accept immediately instead.
    - NONE or MULTI → stay in IDLE.
  - PRESS_DB:
    - SINGLE(cand) → cnt+1; when cnt reaches DEBOUNCE_SCANS, accept and go to HELD.
    - SINGLE(other) → cand=other, cnt=1.
    - NONE or MULTI → IDLE.
  - HELD:
    - NONE → REL_DB, cnt=1. If DEBOUNCE_SCANS=1, go to IDLE.
    - SINGLE or MULTI → stay in HELD.
  - REL_DB:
    - NONE → cnt+1; when cnt reaches DEBOUNCE_SCANS, go to IDLE.
    - SINGLE or MULTI → HELD.
- Accept (occurs on the cycle after the scan boundary):
  - key_valid=1 for exactly one cycle; key_code=cand.
  - digits <= {digits[11:0], cand}.
  - digit_count <= min(digit_count+1, 4).
  - Once the buffer is full, further digits shift the oldest out (wrap-around); digit_count stays at 4.
- Held keys: a held key never repeats. One press produces exactly one accept.
- clear:
  - On any cycle, sets digits=0 and digit_count=0. key_code is unchanged.
  - Does not affect the scan or FSM.
  - If clear coincides with an accept cycle, clear wins for digits/digit_count (both end at 0). key_valid and key_code still report the key.
- Latency: an accept occurs between DEBOUNCE_SCANS and DEBOUNCE_SCANS+1 full scans after a stable press appears, plus 3 cycles.
- Widths: all counters are sized from the parameters. The divider never overflows within a column slot.

Test Plan (SCAN_DIV=8, DEBOUNCE_SCANS=2, bench keypad model pulls row low when the pressed key's column is driven):
- Reset, then no keys for 5 scans → col cycles 1110/1101/1011/0111 at 8 cycles each; key_valid never asserts; digits=0, digit_count=0.
- Press "5" (r1,c1) held 6 scans, then release → exactly one key_valid pulse; key_code=5, digits=16'h0005, digit_count=1.
- Press and release 1, A, 3, F, 7 in sequence → digits=16'h1A3F after the fourth key, then 16'hA3F7 after the fifth; digit_count=4 throughout the fifth key.
- Press "9" for only 1 scan, and separately press "2"+"3" together for 5 scans → no key_valid; digits unchanged.
- Hold "C", drop it for 1 scan, restore it for 3 scans, then release for 3 scans → one accept only (bounce absorbed in REL_DB); FSM returns to IDLE.
- Assert clear on the same cycle as the accept of "E" with digits=16'h1234 → key_valid=1, key_code=E, digits=0, digit_count=0. Assert rst mid-PRESS_DB → all outputs return to reset values; col=1110 on the next cycle.
